// File: rtl/kyber_pkg.sv
// Shared Kyber ByteEncode constants: legal coefficient widths, per-width word counts, FSM states.
package kyber_pkg;

    localparam logic [3:0] L1  = 4'd1;
    localparam logic [3:0] L4  = 4'd4;
    localparam logic [3:0] L5  = 4'd5;
    localparam logic [3:0] L10 = 4'd10;
    localparam logic [3:0] L11 = 4'd11;
    localparam logic [3:0] L12 = 4'd12;
    localparam int         NUM_L = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_legal_l(input logic [3:0] l);
        return (l == L1) || (l == L4) || (l == L5) || (l == L10) || (l == L11) || (l == L12);
    endfunction

    // Index-to-width map used to elaborate one fixed bit mapping per legal width.
    function automatic int legal_l_at(input int idx);
        case (idx)
            0:       return 1;
            1:       return 4;
            2:       return 5;
            3:       return 10;
            4:       return 11;
            default: return 12;
        endcase
    endfunction

    function automatic logic [6:0] coeffs_per_word(input logic [3:0] l);
        case (l)
            L1:       return 7'd64;
            L4:       return 7'd16;
            L5:       return 7'd12;
            L10:      return 7'd6;
            L11, L12: return 7'd5;
            default:  return 7'd0;
        endcase
    endfunction

    function automatic logic [5:0] in_words(input logic [3:0] l);
        case (l)
            L1:       return 6'd4;
            L4:       return 6'd16;
            L5:       return 6'd22;
            L10:      return 6'd43;
            L11, L12: return 6'd52;
            default:  return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] out_words(input logic [3:0] l);
        return {l, 2'b00};
    endfunction

endpackage

// File: rtl/encode_word_pack.sv
// Turns one MSB-first coefficient word into an LSB-first stream fragment of nvalid*l bits.
module encode_word_pack
    import kyber_pkg::*;
(
    input  logic [3:0]  l,
    input  logic [63:0] coeffs,
    input  logic [6:0]  nvalid,
    output logic [63:0] frag,
    output logic [6:0]  len
);

    logic [63:0] packed_w [NUM_L];
    logic [63:0] sel;
    logic [63:0] mask;

    genvar gw, gi;
    generate
        for (gw = 0; gw < NUM_L; gw++) begin : g_width
            localparam int W = legal_l_at(gw);
            localparam int N = 64 / W;
            // Stream bit gi is bit (gi%W) of coefficient gi/W, whose LSB sits at 64-(j+1)*W.
            for (gi = 0; gi < N * W; gi++) begin : g_bit
                assign packed_w[gw][gi] = coeffs[64 - (gi / W + 1) * W + gi % W];
            end
            if (N * W < 64) begin : g_pad
                assign packed_w[gw][63:N*W] = '0;
            end
        end
    endgenerate

    always_comb begin
        sel = '0;
        case (l)
            L1:      sel = packed_w[0];
            L4:      sel = packed_w[1];
            L5:      sel = packed_w[2];
            L10:     sel = packed_w[3];
            L11:     sel = packed_w[4];
            L12:     sel = packed_w[5];
            default: sel = '0;
        endcase
        len  = nvalid * 7'(l);
        mask = (len == 7'd64) ? '1 : ((64'd1 << len) - 64'd1);
        frag = sel & mask;
    end

endmodule

// File: rtl/encode.sv
// ByteEncode_l engine: packs 256 l-bit coefficients into 4*l stream words of 64 bits.
module encode
    import kyber_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [3:0]  i_l,
    input  logic [63:0] i_coeffs,
    input  logic        i_coeffs_valid,
    output logic        o_coeffs_ready,
    output logic [63:0] o_obytes,
    output logic        o_obytes_valid,
    input  logic        i_obytes_ready,
    output logic        o_done
);

    state_t       state;
    logic [3:0]   l_reg;
    logic [127:0] acc;
    logic [7:0]   cnt;
    logic [8:0]   coeff_cnt;
    logic [5:0]   out_cnt;

    logic [8:0]   remaining;
    logic [6:0]   nper;
    logic [6:0]   nvalid;
    logic [63:0]  frag;
    logic [6:0]   frag_len;
    logic         push, load, xfer, last_in;
    logic [127:0] acc_shift, acc_next;
    logic [7:0]   cnt_base, cnt_next;
    logic [63:0]  acc_bytes;

    encode_word_pack u_pack (
        .l      (l_reg),
        .coeffs (i_coeffs),
        .nvalid (nvalid),
        .frag   (frag),
        .len    (frag_len)
    );

    assign o_coeffs_ready = (state == S_RUN) && (cnt < 8'd64);
    assign remaining      = 9'd256 - coeff_cnt;
    assign nper           = coeffs_per_word(l_reg);
    assign nvalid         = (remaining < {2'b00, nper}) ? remaining[6:0] : nper;
    assign push           = i_coeffs_valid && o_coeffs_ready;
    assign load           = (cnt >= 8'd64) && (!o_obytes_valid || i_obytes_ready);
    assign xfer           = o_obytes_valid && i_obytes_ready;
    assign last_in        = push && ((coeff_cnt + 9'(nvalid)) == 9'd256);

    // A load retires the low 64 bits first; a same-cycle push then lands above what remains.
    always_comb begin
        acc_shift = load ? {64'd0, acc[127:64]} : acc;
        cnt_base  = load ? (cnt - 8'd64) : cnt;
        acc_next  = acc_shift;
        cnt_next  = cnt_base;
        if (push) begin
            acc_next = acc_shift | ({64'd0, frag} << cnt_base);
            cnt_next = cnt_base + {1'b0, frag_len};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign acc_bytes[63-8*gi -: 8] = acc[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= S_IDLE;
            l_reg          <= '0;
            acc            <= '0;
            cnt            <= '0;
            coeff_cnt      <= '0;
            out_cnt        <= '0;
            o_obytes       <= '0;
            o_obytes_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && is_legal_l(i_l)) begin
                        l_reg     <= i_l;
                        acc       <= '0;
                        cnt       <= '0;
                        coeff_cnt <= '0;
                        out_cnt   <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    if (push)
                        coeff_cnt <= coeff_cnt + 9'(nvalid);
                    if (load) begin
                        o_obytes       <= acc_bytes;
                        o_obytes_valid <= 1'b1;
                    end else if (xfer) begin
                        o_obytes_valid <= 1'b0;
                    end
                    if (xfer)
                        out_cnt <= out_cnt + 6'd1;
                    if (state == S_RUN && last_in)
                        state <= S_DRAIN;
                    if (state == S_DRAIN && xfer && out_cnt == out_words(l_reg) - 6'd1) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: directed vectors, random-stall run and decode round trips.
module tb_encode;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  i_l = 4'd0;
    logic [63:0] i_coeffs = '0;
    logic        i_coeffs_valid = 1'b0;
    logic        o_coeffs_ready;
    logic [63:0] o_obytes;
    logic        o_obytes_valid;
    logic        i_obytes_ready = 1'b1;
    logic        o_done;

    encode dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_start        (i_start),
        .i_l            (i_l),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_obytes       (o_obytes),
        .o_obytes_valid (o_obytes_valid),
        .i_obytes_ready (i_obytes_ready),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          passes = 0;
    logic [63:0] exp_q [$];
    logic [63:0] cap [$];
    logic [11:0] coef [256];
    bit          capture = 1'b0;
    bit          rand_rdy = 1'b0;
    int          out_count = 0;
    int          done_seen = 0;
    bit          stall_prev = 1'b0;
    logic [63:0] held_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_obytes_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks stall stability and ready gating.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (stall_prev) begin
                chk("stall_valid", 64'(o_obytes_valid), 64'd1);
                chk("stall_data", o_obytes, held_word);
            end
            if (o_obytes_valid && i_obytes_ready) begin
                out_count++;
                if (capture) cap.push_back(o_obytes);
                else if (exp_q.size() == 0) chk("unexpected_output", o_obytes, 64'hx);
                else chk($sformatf("out_word_%0d", out_count - 1), o_obytes, exp_q.pop_front());
            end
            if (dut.cnt >= 8'd64) chk("ready_low_when_full", 64'(o_coeffs_ready), 64'd0);
            if (o_done) done_seen++;
            stall_prev = o_obytes_valid && !i_obytes_ready;
            held_word  = o_obytes;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic int n_in(input int l);
        int n = 64 / l;
        return (256 + n - 1) / n;
    endfunction

    // Reference FIPS 203 packing: coefficient i bit b is stream bit i*l+b, byte s/8 bit s%8.
    task automatic model_push(input int l);
        logic bits [3072];
        logic [63:0] w;
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < l; b++) bits[i*l+b] = coef[i][b];
        for (int wi = 0; wi < 4 * l; wi++) begin
            w = '0;
            for (int k = 0; k < 8; k++)
                for (int b = 0; b < 8; b++) w[56-8*k+b] = bits[(8*wi+k)*8+b];
            exp_q.push_back(w);
        end
    endtask

    task automatic start_run(input logic [3:0] l);
        i_start = 1'b1;
        i_l = l;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic drive_poly(input int l, input bit fill_rand, input bit start_mid, input int nwords);
        int n = 64 / l;
        int t;
        logic [63:0] word;
        for (int w = 0; w < nwords; w++) begin
            word = fill_rand ? {$urandom(), $urandom()} : 64'd0;
            for (int k = 0; k < n; k++) begin
                int idx = w * n + k;
                if (idx < 256)
                    for (int b = 0; b < l; b++) word[64-(k+1)*l+b] = coef[idx][b];
            end
            i_coeffs = word;
            i_coeffs_valid = 1'b1;
            if (start_mid && w == 5) begin
                i_start = 1'b1;
                i_l = 4'd1;
            end
            t = 0;
            do begin
                @(negedge i_clk);
                t++;
            end while (!o_coeffs_ready && t < 500);
            if (!o_coeffs_ready) begin
                chk("input_accept_timeout", 64'(w), 64'(nwords));
                i_coeffs_valid = 1'b0;
                i_start = 1'b0;
                return;
            end
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
        end
        i_coeffs_valid = 1'b0;
    endtask

    task automatic run_poly(input string name, input int l, input bit fill_rand, input bit start_mid);
        int t = 0;
        done_seen = 0;
        out_count = 0;
        start_run(4'(l));
        drive_poly(l, fill_rand, start_mid, n_in(l));
        while (done_seen == 0 && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        repeat (3) @(negedge i_clk);
        chk({name, "_done_pulses"}, 64'(done_seen), 64'd1);
        chk({name, "_out_count"}, 64'(out_count), 64'(4 * l));
        chk({name, "_cnt_zero"}, 64'(dut.cnt), 64'd0);
        if (!capture) chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        $display("run %s l=%0d: %0d outputs, %0d done pulses", name, l, out_count, done_seen);
    endtask

    task automatic round_trip(input int l);
        int bad = 0;
        int s;
        logic [11:0] v;
        for (int i = 0; i < 256; i++) coef[i] = 12'($urandom()) & 12'((1 << l) - 1);
        capture = 1'b1;
        cap.delete();
        run_poly($sformatf("rt_l%0d", l), l, 1'b1, 1'b0);
        chk($sformatf("rt_l%0d_words", l), 64'(cap.size()), 64'(4 * l));
        if (cap.size() == 4 * l) begin
            for (int i = 0; i < 256; i++) begin
                v = '0;
                for (int b = 0; b < l; b++) begin
                    s = i * l + b;
                    v[b] = cap[s/64][56 - 8*((s%64)/8) + s%8];
                end
                if (v != coef[i]) bad++;
            end
        end else begin
            bad = -1;
        end
        chk($sformatf("rt_l%0d_coeff_mismatches", l), 64'(bad), 64'd0);
        capture = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_obytes", o_obytes, 64'd0);
        chk("reset_obytes_valid", 64'(o_obytes_valid), 64'd0);
        chk("reset_coeffs_ready", 64'(o_coeffs_ready), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;

        // l=4, coefficient i = i mod 16: every input word is 0x0123456789ABCDEF.
        for (int i = 0; i < 256; i++) coef[i] = 12'(i % 16);
        repeat (16) exp_q.push_back(64'h1032547698BADCFE);
        run_poly("l4", 4, 1'b0, 1'b0);

        // l=1, only coefficient 0 of each word set: each input word is 0x8000000000000000.
        for (int i = 0; i < 256; i++) coef[i] = (i % 64 == 0) ? 12'd1 : 12'd0;
        repeat (4) exp_q.push_back(64'h0100000000000000);
        run_poly("l1", 1, 1'b0, 1'b0);

        // l=12 all ones, ignored fields of every word random.
        for (int i = 0; i < 256; i++) coef[i] = 12'hFFF;
        repeat (48) exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
        run_poly("l12", 12, 1'b1, 1'b0);

        // l=11 with downstream stalling at random.
        for (int i = 0; i < 256; i++) coef[i] = 12'($urandom()) & 12'h7FF;
        model_push(11);
        rand_rdy = 1'b1;
        run_poly("l11_stall", 11, 1'b1, 1'b0);
        rand_rdy = 1'b0;

        round_trip(5);
        round_trip(10);

        // Illegal width: start must be ignored.
        out_count = 0;
        start_run(4'd7);
        repeat (3) @(negedge i_clk);
        chk("illegal_l_state_idle", 64'(dut.state), 64'(kyber_pkg::S_IDLE));
        chk("illegal_l_not_ready", 64'(o_coeffs_ready), 64'd0);
        chk("illegal_l_no_output", 64'(out_count), 64'd0);
        $display("run illegal l=7: state %0d", dut.state);

        // Start pulse with a new width in mid-run must not disturb the l=4 run.
        for (int i = 0; i < 256; i++) coef[i] = 12'(i % 16);
        repeat (16) exp_q.push_back(64'h1032547698BADCFE);
        run_poly("l4_start_mid", 4, 1'b0, 1'b1);

        // Asynchronous reset in mid-run.
        capture = 1'b1;
        for (int i = 0; i < 256; i++) coef[i] = 12'($urandom()) & 12'h7FF;
        start_run(4'd11);
        drive_poly(11, 1'b0, 1'b0, 10);
        i_coeffs_valid = 1'b1;
        #3;
        i_rstn = 1'b0;
        #1;
        chk("midrst_obytes", o_obytes, 64'd0);
        chk("midrst_obytes_valid", 64'(o_obytes_valid), 64'd0);
        chk("midrst_coeffs_ready", 64'(o_coeffs_ready), 64'd0);
        chk("midrst_done", 64'(o_done), 64'd0);
        $display("run mid-run reset: outputs cleared");
        i_coeffs_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        capture = 1'b0;
        exp_q.delete();

        // Clean l=4 run after the abandoned one.
        for (int i = 0; i < 256; i++) coef[i] = 12'(i % 16);
        repeat (16) exp_q.push_back(64'h1032547698BADCFE);
        run_poly("l4_after_reset", 4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
